// File: rtl/checkers_pkg.sv
// Shared constants for the checkers VGA display: 640x480@60 timing, palette,
// per-square piece field layout and legal-move slot layout.
package checkers_pkg;

  typedef logic [9:0] cnt_t;
  typedef logic [23:0] rgb_t;

  localparam cnt_t H_ACTIVE     = 10'd640;
  localparam cnt_t H_FP         = 10'd16;
  localparam cnt_t H_SYNC       = 10'd96;
  localparam cnt_t H_BP         = 10'd48;
  localparam cnt_t H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam cnt_t H_LAST       = H_TOTAL - 10'd1;
  localparam cnt_t H_SYNC_START = H_ACTIVE + H_FP;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

  localparam cnt_t V_ACTIVE     = 10'd480;
  localparam cnt_t V_FP         = 10'd10;
  localparam cnt_t V_SYNC       = 10'd2;
  localparam cnt_t V_BP         = 10'd33;
  localparam cnt_t V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t V_LAST       = V_TOTAL - 10'd1;
  localparam cnt_t V_SYNC_START = V_ACTIVE + V_FP;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

  localparam int unsigned PIECE_PRESENT = 2;
  localparam int unsigned PIECE_RED     = 1;
  localparam int unsigned PIECE_KING    = 0;
  localparam int unsigned PIECE_W       = 3;
  localparam int unsigned N_SQUARES     = 64;
  localparam int unsigned LEGAL_SLOT_W  = 7;
  localparam int unsigned N_LEGAL       = 4;

  localparam rgb_t COL_BLACK  = 24'h000000;
  localparam rgb_t COL_CURSOR = 24'hFFFF00;
  localparam rgb_t COL_KING   = 24'hFFD700;
  localparam rgb_t COL_RED    = 24'hFF0000;
  localparam rgb_t COL_WHITE  = 24'hFFFFFF;
  localparam rgb_t COL_LEGAL  = 24'h00A000;
  localparam rgb_t COL_DARK   = 24'h804000;
  localparam rgb_t COL_LIGHT  = 24'hF0D9B5;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus 800x525 raster counters; derives raw syncs, active
// video and the once-per-frame snapshot strobe at the start of line 480.
module vga_timing_gen
  import checkers_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en_o,
  output cnt_t h_o,
  output cnt_t v_o,
  output logic hs_o,
  output logic vs_o,
  output logic active_o,
  output logic frame_start_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  cnt_t h_q, h_d, v_q, v_d;

  always_comb begin
    pix_en_o = (div_q == '0);
    div_d    = pix_en_o ? DIV_W'(CLK_DIV - 1) : div_q - DIV_W'(1);
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en_o) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
      if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hs_o          = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
  assign vs_o          = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
  assign active_o      = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
  assign frame_start_o = pix_en_o && (h_q == '0) && (v_q == V_ACTIVE);

endmodule

// File: rtl/board_vga_renderer.sv
// Draws the checkers board, pieces, legal-move hints and cursor from a per-frame
// snapshot of the game state; two-stage pixel pipeline with syncs delayed to match.
module board_vga_renderer
  import checkers_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SQ_SIZE  = 48,
  parameter int unsigned BOARD_X0 = 128,
  parameter int unsigned BOARD_Y0 = 48,
  parameter int unsigned PIECE_R2 = 324,
  parameter int unsigned KING_R2  = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_SQUARES*PIECE_W-1:0]      serialized_board,
  input  logic [N_LEGAL*LEGAL_SLOT_W-1:0]   legal_move,
  input  logic [5:0]                        cursor_loc,
  output logic [7:0]                        vga_r,
  output logic [7:0]                        vga_g,
  output logic [7:0]                        vga_b,
  output logic                              vga_hs,
  output logic                              vga_vs,
  output logic                              vga_blank_n,
  output logic                              vga_sync_n,
  output logic                              vga_clk,
  output logic                              frame_start
);

  localparam int unsigned SQ_W = $clog2(SQ_SIZE);
  localparam int unsigned D2_W = 2 * SQ_W + 1;
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQ_SIZE - 1);
  localparam logic [SQ_W-1:0] SQ_HALF = SQ_W'(SQ_SIZE / 2);
  localparam logic [SQ_W-1:0] EDGE_LO = SQ_W'(3);
  localparam logic [SQ_W-1:0] EDGE_HI = SQ_W'(SQ_SIZE - 3);
  localparam logic [D2_W-1:0] KING_LIM  = D2_W'(KING_R2);
  localparam logic [D2_W-1:0] PIECE_LIM = D2_W'(PIECE_R2);
  localparam cnt_t X0    = cnt_t'(BOARD_X0);
  localparam cnt_t X_PRE = cnt_t'(BOARD_X0 - 1);
  localparam cnt_t X_END = cnt_t'(BOARD_X0 + 8 * SQ_SIZE);
  localparam cnt_t Y0    = cnt_t'(BOARD_Y0);
  localparam cnt_t Y_END = cnt_t'(BOARD_Y0 + 8 * SQ_SIZE);

  typedef struct packed {
    logic            active;
    logic            board;
    logic            cursor;
    logic            present;
    logic            red;
    logic            king;
    logic [D2_W-1:0] d2;
    logic            legal;
    logic            dark;
    logic            hs;
    logic            vs;
  } s1_t;

  logic pix_en, hs_raw, vs_raw, active_raw, fs;
  cnt_t h, v, v_next;

  vga_timing_gen #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk           (clk),
    .rst           (rst),
    .pix_en_o      (pix_en),
    .h_o           (h),
    .v_o           (v),
    .hs_o          (hs_raw),
    .vs_o          (vs_raw),
    .active_o      (active_raw),
    .frame_start_o (fs)
  );

  logic [N_SQUARES*PIECE_W-1:0]    snap_board_q;
  logic [N_LEGAL*LEGAL_SLOT_W-1:0] snap_legal_q;
  logic [5:0]                      snap_cursor_q;

  logic [SQ_W-1:0] sq_px_q, sq_px_d, sq_py_q, sq_py_d;
  logic [2:0]      col_q, col_d, row_q, row_d;

  // Square position follows the raster incrementally, re-synced at the board's left/top edge.
  always_comb begin
    sq_px_d = sq_px_q;
    col_d   = col_q;
    sq_py_d = sq_py_q;
    row_d   = row_q;
    v_next  = (v == V_LAST) ? '0 : v + 10'd1;
    if (pix_en) begin
      if (h == X_PRE) begin
        sq_px_d = '0;
        col_d   = '0;
      end else if (sq_px_q == SQ_LAST) begin
        sq_px_d = '0;
        col_d   = col_q + 3'd1;
      end else begin
        sq_px_d = sq_px_q + SQ_W'(1);
      end
      if (h == H_LAST) begin
        if (v_next == Y0) begin
          sq_py_d = '0;
          row_d   = '0;
        end else if (sq_py_q == SQ_LAST) begin
          sq_py_d = '0;
          row_d   = row_q + 3'd1;
        end else begin
          sq_py_d = sq_py_q + SQ_W'(1);
        end
      end
    end
  end

  logic [2:0]              bx, by;
  logic [5:0]              sq_idx;
  logic [PIECE_W-1:0]      sq_bits;
  logic [LEGAL_SLOT_W-1:0] slot;
  logic [SQ_W-1:0]         adx, ady;
  logic                    border;
  s1_t                     s1_q, s1_d;

  always_comb begin
    bx      = col_q;
    by      = 3'd7 - row_q;
    sq_idx  = {bx, by};
    sq_bits = snap_board_q[int'(sq_idx) * PIECE_W +: PIECE_W];
    adx     = (sq_px_q >= SQ_HALF) ? sq_px_q - SQ_HALF : SQ_HALF - sq_px_q;
    ady     = (sq_py_q >= SQ_HALF) ? sq_py_q - SQ_HALF : SQ_HALF - sq_py_q;
    border  = (sq_px_q < EDGE_LO) || (sq_px_q >= EDGE_HI) ||
              (sq_py_q < EDGE_LO) || (sq_py_q >= EDGE_HI);
    slot    = '0;
    s1_d    = '0;
    s1_d.active  = active_raw;
    s1_d.board   = active_raw && (h >= X0) && (h < X_END) && (v >= Y0) && (v < Y_END);
    s1_d.cursor  = border && (snap_cursor_q == sq_idx);
    s1_d.present = sq_bits[PIECE_PRESENT];
    s1_d.red     = sq_bits[PIECE_RED];
    s1_d.king    = sq_bits[PIECE_KING];
    s1_d.d2      = D2_W'(adx) * D2_W'(adx) + D2_W'(ady) * D2_W'(ady);
    for (int k = 0; k < N_LEGAL; k++) begin
      slot = snap_legal_q[k * LEGAL_SLOT_W +: LEGAL_SLOT_W];
      if (slot[LEGAL_SLOT_W-1] && (slot[5:0] == sq_idx)) s1_d.legal = 1'b1;
    end
    s1_d.dark = !(bx[0] ^ by[0]);
    s1_d.hs   = hs_raw;
    s1_d.vs   = vs_raw;
  end

  rgb_t rgb_q, rgb_d;
  logic hs_q, vs_q, blank_n_q, vga_clk_q;

  always_comb begin
    rgb_d = COL_BLACK;
    if (!s1_q.board)                                          rgb_d = COL_BLACK;
    else if (s1_q.cursor)                                     rgb_d = COL_CURSOR;
    else if (s1_q.present && s1_q.king && s1_q.d2 <= KING_LIM) rgb_d = COL_KING;
    else if (s1_q.present && s1_q.d2 <= PIECE_LIM)            rgb_d = s1_q.red ? COL_RED : COL_WHITE;
    else if (s1_q.legal)                                      rgb_d = COL_LEGAL;
    else                                                      rgb_d = s1_q.dark ? COL_DARK : COL_LIGHT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_board_q  <= '0;
      snap_legal_q  <= '0;
      snap_cursor_q <= '0;
      sq_px_q       <= '0;
      col_q         <= '0;
      sq_py_q       <= '0;
      row_q         <= '0;
      s1_q          <= '0;
      s1_q.hs       <= 1'b1;
      s1_q.vs       <= 1'b1;
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      vga_clk_q     <= 1'b0;
    end else begin
      if (fs) begin
        snap_board_q  <= serialized_board;
        snap_legal_q  <= legal_move;
        snap_cursor_q <= cursor_loc;
      end
      sq_px_q   <= sq_px_d;
      col_q     <= col_d;
      sq_py_q   <= sq_py_d;
      row_q     <= row_d;
      vga_clk_q <= pix_en;
      if (pix_en) begin
        s1_q      <= s1_d;
        rgb_q     <= rgb_d;
        hs_q      <= s1_q.hs;
        vs_q      <= s1_q.vs;
        blank_n_q <= s1_q.active;
      end
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = vga_clk_q;
  assign frame_start = fs;

endmodule
